// File: rtl/layer2_result_pkg.sv
// layer2_result_pkg: shared types, constants and helpers for the layer-2 result readout.
package layer2_result_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [15:0] STATUS_OFFSET = 16'hFFFC;
    localparam int LANE_W = 16;
    localparam int LANES = 8;
    localparam int WORD_W = LANE_W * LANES;
    localparam int ST_ERR_BIT = 5;
    localparam int ST_OVF_BIT = 4;

    function automatic logic [WORD_W-1:0] relu(input logic [WORD_W-1:0] d);
        relu = d;
        for (int k = 0; k < LANES; k++)
            if (d[k*LANE_W+LANE_W-1]) relu[k*LANE_W +: LANE_W] = '0;
    endfunction

endpackage

// File: rtl/layer2_result_readout_ram.sv
// result_store_ram: one-write one-read synchronous RAM, reads return pre-write contents.
module result_store_ram #(
    parameter int DEPTH = 784,
    parameter int AW = 10,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // write and registered read on the same edge; nonblocking write yields old data
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/layer2_result_readout.sv
// layer2_result_readout: collects layer-2 CNN words into RAM and serves them on the CPU read channel.
// Build option RESULT_RELU_EN clamps negative 16-bit lanes to zero before storage.
module layer2_result_readout
    import layer2_result_pkg::*;
#(
    parameter int          OUT_ROWS = 28,
    parameter int          OUT_COLS = 28,
    parameter logic [15:0] BASE_HI  = 16'h4000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          save_enable,
    input  logic [15:0]   save_row,
    input  logic [15:0]   save_col,
    input  logic [127:0]  save_data,
    input  logic          calculation_done,
    input  logic          result_clear,
    input  logic [31:0]   araddr,
    input  logic          arvalid,
    output logic [31:0]   rdata,
    output logic          rvalid,
    output logic          result_ready,
    output logic          done_pulse
);

    localparam int WORDS = OUT_ROWS * OUT_COLS;
    localparam int AW = $clog2(WORDS);
    localparam int CW = $clog2(WORDS + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_FULL = CW'(WORDS);
    localparam logic [15:0] DATA_LIMIT = 16'(WORDS * 16);

    state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic ovf_q, ovf_d, err_q, err_d;
    logic in_range, wr_en;
    logic [AW-1:0] waddr;
    logic [WORD_W-1:0] wdata, ram_q;
    logic [15:0] offset;
    logic accept, is_data, is_status, sel_data_q;
    logic [1:0] pair_q;
    logic [31:0] status, status_q;

    assign in_range = save_row < 16'(OUT_ROWS) && save_col < 16'(OUT_COLS);
    assign wr_en = save_enable && in_range && !result_clear;
    assign waddr = AW'(save_row) * AW'(OUT_COLS) + AW'(save_col);
`ifdef RESULT_RELU_EN
    assign wdata = relu(save_data);
`else
    assign wdata = save_data;
`endif

    assign offset = araddr[15:0];
    assign accept = arvalid && araddr[31:16] == BASE_HI;
    assign is_data = offset < DATA_LIMIT;
    assign is_status = {offset[15:2], 2'b00} == STATUS_OFFSET;
    assign result_ready = state_q == DONE;
    assign rdata = sel_data_q ? ram_q[{pair_q, 5'b00000} +: 32] : status_q;

    result_store_ram #(.DEPTH(WORDS), .AW(AW), .DW(WORD_W)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (wdata),
        .re    (accept && is_data),
        .raddr (offset[AW+3:4]),
        .rdata (ram_q)
    );

    // next state, saturating word count and sticky flags; clear overrides everything
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d = ovf_q;
        err_d = err_q;
        if (result_clear) begin
            state_d = IDLE;
            count_d = '0;
            ovf_d = 1'b0;
            err_d = 1'b0;
        end else begin
            if (state_q == DONE && save_enable) begin
                count_d = '0;
                ovf_d = 1'b0;
                err_d = 1'b0;
            end
            if (save_enable && !in_range) ovf_d = 1'b1;
            if (wr_en && count_d != CNT_MAX) count_d = count_d + 1'b1;
            if (state_q == DONE) begin
                state_d = save_enable ? COLLECT : DONE;
            end else if (calculation_done) begin
                state_d = DONE;
                err_d = count_d != CNT_FULL;
            end else if (save_enable) begin
                state_d = COLLECT;
            end
        end
    end

    // status word snapshot as seen at read acceptance
    always_comb begin
        status = '0;
        status[ST_ERR_BIT] = err_q;
        status[ST_OVF_BIT] = ovf_q;
        status[1:0] = state_q;
    end

    // state, counters, done pulse and one-cycle read response pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            done_pulse <= 1'b0;
            rvalid <= 1'b0;
            sel_data_q <= 1'b0;
            pair_q <= '0;
            status_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            done_pulse <= state_d == DONE && state_q != DONE;
            rvalid <= accept;
            sel_data_q <= accept && is_data;
            pair_q <= offset[3:2];
            status_q <= accept && is_status ? status : '0;
        end
    end

endmodule

// File: doc/layer2_result_readout.md
Name: layer2_result_readout

Overview:
- Downstream consumer of the layer2_cnn stage.
- Captures each 128-bit layer-2 output word, addressed by output row/col, into a local result RAM.
- Tracks collection progress and raises a one-cycle done pulse when layer-2 calculation finishes.
- Serves CPU reads over the araddr/arvalid read channel as 32-bit rdata, making final CNN results visible on the bus.

Parameters:
- OUT_ROWS, 28, number of layer-2 output rows stored
- OUT_COLS, 28, number of layer-2 output columns stored
- BASE_HI, 16'h4000, araddr[31:16] value that selects this block

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- save_enable  input  1  layer-2 output word valid this cycle
- save_row  input  16  output row of save_data
- save_col  input  16  output column of save_data
- save_data  input  128  eight signed 16-bit channel results; lane k = bits [16k+15:16k]
- calculation_done  input  1  layer-2 finished (pulse)
- result_clear  input  1  synchronous return to IDLE and clear of flags
- araddr  input  32  CPU read address
- arvalid  input  1  CPU read request
- rdata  output  32  read data
- rvalid  output  1  rdata valid
- result_ready  output  1  level, high in DONE
- done_pulse  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset values: all outputs 0; state IDLE; word count, overflow flag and count_error flag all 0. RAM contents are not reset.
- Word index = save_row*OUT_COLS + save_col.
- A write occurs on save_enable only when save_row<OUT_ROWS and save_col<OUT_COLS.
  - Out-of-range writes are dropped and set the sticky overflow flag.
  - Each accepted write increments the count (width clog2(OUT_ROWS*OUT_COLS+1)).
  - The count saturates at its maximum; no wrap.
- State machine:
  - IDLE -> COLLECT on save_enable.
  - COLLECT -> DONE on calculation_done.
  - DONE -> COLLECT on save_enable: count and flags cleared, the new word is written and counted as 1.
  - calculation_done in IDLE -> DONE, with count 0 and count_error set.
  - On entry to DONE, count_error is set if count != OUT_ROWS*OUT_COLS.
- Simultaneous save_enable and calculation_done in COLLECT: the word is written and counted, then the FSM goes to DONE; count_error is evaluated including that word.
- done_pulse is high exactly in the first cycle that state==DONE. result_ready is high while state==DONE.
- result_clear has priority over all other inputs: state -> IDLE; count and flags cleared; RAM untouched; a coincident write is dropped.
- Read handshake: a request is accepted when arvalid=1 and araddr[31:16]==BASE_HI. Off-block addresses are ignored (no rvalid).
  - Latency is 1: rvalid=1 and rdata valid in the cycle after acceptance.
  - Back-to-back reads every cycle are supported.
  - offset = araddr[15:0]. Offset bits [1:0] are ignored.
  - Data region, offset < OUT_ROWS*OUT_COLS*16: word = offset[15:4], lane pair = offset[3:2]; rdata = word_data[32*pair+31:32*pair].
  - Offset 16'hFFFC = status: {26'b0, count_error, overflow, 2'b0, state[1:0]}, with IDLE=0, COLLECT=1, DONE=2.
  - Any other offset returns 32'h0 with rvalid=1.
- Data reads are served in every state and return the current RAM contents. A read and a write to the same word in the same cycle return the old data.
- Asynchronous reset mid-collection aborts the collection: state IDLE, rvalid=0, count 0.

Optional Feature:
- Macro RESULT_RELU_EN.
- When defined: each signed 16-bit lane of save_data is clamped to 0 if negative before storage.
- When undefined: save_data is stored unmodified.
- Counting, flags and timing are identical in both builds.

Decomposition:
- Package layer2_result_pkg holds:
  - state enum (IDLE, COLLECT, DONE)
  - STATUS_OFFSET = 16'hFFFC
  - LANE_W = 16, LANES = 8
  - status bit positions
- One sub-module, result_store_ram: OUT_ROWS*OUT_COLS x 128-bit RAM with synchronous write and synchronous read, single write port plus single read port, read-before-write.

Test Plan:
- Reset, then read status at 32'h4000_FFFC -> rvalid one cycle later, rdata=32'h0.
- Write all 784 words with data = index replicated per lane, then pulse calculation_done.
  - Expect done_pulse for 1 cycle, result_ready=1, status=32'h2.
  - Read 32'h4000_0010 -> 32'h0001_0001.
- save_row=28, save_col=0 with save_enable -> no RAM change; status bit 4 (overflow) set.
- Only 10 writes, then calculation_done -> status=32'h0000_0022 (count_error + DONE).
- save_enable and calculation_done in the same cycle as the 784th write -> count_error=0, final word readable.
- RESULT_RELU_EN defined, write lane0=16'h8001, lane1=16'h0005 at word 0.
  - Read 32'h4000_0000 -> 32'h0005_0000.
  - Undefined build -> 32'h0005_8001.
